// File: rtl/gpio_sw_debouncer_if.sv
// Switch-side bundle of the GPIO switch debouncer: raw switch levels in,
// debounced levels and edge events out.
interface gpio_sw_debouncer_if #(
    parameter int WIDTH = 9
);
    logic [WIDTH-1:0] SW_i;
    logic [WIDTH-1:0] GPIO_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic             changed_o;

    // master: the switch/board side that drives raw levels and observes results
    modport master (
        output SW_i,
        input  GPIO_o,
        input  rise_o,
        input  fall_o,
        input  changed_o
    );

    // slave: the debouncer itself
    modport slave (
        input  SW_i,
        output GPIO_o,
        output rise_o,
        output fall_o,
        output changed_o
    );
endinterface

// File: rtl/gpio_sw_debouncer.sv
// Slide-switch conditioner for CoreMips GPIO_i: two-flop synchroniser, per-bit
// stability counter, registered debounced levels and one-cycle rise/fall events.
module gpio_sw_debouncer #(
    parameter int WIDTH         = 9,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    gpio_sw_debouncer_if.slave  bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] gpio_q, gpio_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] flip;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        s1_d   = bus.SW_i;
        s2_d   = s1_q;
        gpio_d = gpio_q;
        flip   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // An agreeing cycle drops the bit back to idle; a bounce restarts the full count.
            if (s2_q[i] != gpio_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    flip[i]   = 1'b1;
                    gpio_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        rise_d    = flip & s2_q;
        fall_d    = flip & ~s2_q;
        changed_d = |flip;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            gpio_q    <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            // NOTE: the counter array is ordinary state, not RAM, so it is reset like any flop; a discarded pending count must not survive reset.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            gpio_q    <= gpio_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.GPIO_o    = gpio_q;
    assign bus.rise_o    = rise_q;
    assign bus.fall_o    = fall_q;
    assign bus.changed_o = changed_q;

endmodule

// File: tb/tb_gpio_sw_debouncer.sv
// Scoreboard bench for gpio_sw_debouncer with STABLE_CYCLES=4: expected events
// are queued when switches are driven and matched when pulses appear.
module tb_gpio_sw_debouncer;

    localparam int WIDTH = 9;
    localparam int SC    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gpio_sw_debouncer_if #(.WIDTH(WIDTH)) bus ();

    gpio_sw_debouncer #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        int               edge_no;
        logic [WIDTH-1:0] gpio;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        logic             changed;
    } ev_t;

    ev_t              sb[$];
    ev_t              mon_e;
    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] exp_gpio = '0;

    // Event monitor: any pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (bus.rise_o != '0 || bus.fall_o != '0 || bus.changed_o)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event edge=%0d gpio=%h rise=%h fall=%h changed=%b, required no event",
                         edge_cnt, bus.GPIO_o, bus.rise_o, bus.fall_o, bus.changed_o);
            end else begin
                mon_e = sb.pop_front();
                if (edge_cnt !== mon_e.edge_no || bus.GPIO_o !== mon_e.gpio ||
                    bus.rise_o !== mon_e.rise || bus.fall_o !== mon_e.fall ||
                    bus.changed_o !== mon_e.changed) begin
                    failures++;
                    $display("FAIL event edge=%0d gpio=%h rise=%h fall=%h changed=%b, required edge=%0d gpio=%h rise=%h fall=%h changed=%b",
                             edge_cnt, bus.GPIO_o, bus.rise_o, bus.fall_o, bus.changed_o,
                             mon_e.edge_no, mon_e.gpio, mon_e.rise, mon_e.fall, mon_e.changed);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Queue the event a held vector v should produce; capture is the next edge.
    task automatic expect_hold(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] f;
        r = v & ~exp_gpio;
        f = ~v & exp_gpio;
        if ((r | f) != '0) begin
            sb.push_back('{edge_cnt + SC + 2, v, r, f, 1'b1});
        end
        exp_gpio = v;
    endtask

    task automatic drive_hold(input logic [WIDTH-1:0] v);
        bus.SW_i = v;
        expect_hold(v);
    endtask

    task automatic wait_until(input int e);
        for (int i = 0; i < 100 && edge_cnt < e; i++) tick(1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick(1);
        tick(2);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
            sb.delete();
        end
        checks++;
        if (bus.GPIO_o !== exp_gpio) begin
            failures++;
            $display("FAIL %s_settled gpio=%h required=%h", name, bus.GPIO_o, exp_gpio);
        end
    endtask

    // Checks GPIO_o is still old_v one edge before the flip and new_v at the flip edge.
    task automatic check_flip_edge(input string name, input int cap,
                                   input logic [WIDTH-1:0] old_v, input logic [WIDTH-1:0] new_v);
        wait_until(cap + SC);
        checks++;
        if (edge_cnt !== cap + SC || bus.GPIO_o !== old_v) begin
            failures++;
            $display("FAIL %s_pre edge=%0d gpio=%h required edge=%0d gpio=%h",
                     name, edge_cnt, bus.GPIO_o, cap + SC, old_v);
        end
        tick(1);
        checks++;
        if (bus.GPIO_o !== new_v) begin
            failures++;
            $display("FAIL %s_flip edge=%0d gpio=%h required=%h", name, edge_cnt, bus.GPIO_o, new_v);
        end
    endtask

    task automatic test_reset;
        bus.SW_i = '1;
        rst      = 1'b1;
        tick(3);
        checks++;
        if ({bus.GPIO_o, bus.rise_o, bus.fall_o, bus.changed_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs gpio=%h rise=%h fall=%h changed=%b required all 0",
                     bus.GPIO_o, bus.rise_o, bus.fall_o, bus.changed_o);
        end
        rst = 1'b0;
        expect_hold('1);
        wait_drain("reset_release");
        drive_hold('0);
        wait_drain("reset_all_fall");
    endtask

    task automatic test_latency;
        int cap;
        cap = edge_cnt + 1;
        drive_hold(9'h001);
        check_flip_edge("latency_rise", cap, 9'h000, 9'h001);
        wait_drain("latency_rise");
        cap = edge_cnt + 1;
        drive_hold(9'h000);
        check_flip_edge("latency_fall", cap, 9'h001, 9'h000);
        wait_drain("latency_fall");
    endtask

    task automatic test_bounce;
        int cap;
        for (int k = 0; k < 4; k++) begin
            bus.SW_i[3] = (k % 2 == 0);
            tick(2);
        end
        cap = edge_cnt + 1;
        drive_hold(9'h008);
        check_flip_edge("bounce", cap, 9'h000, 9'h008);
        wait_drain("bounce");
        drive_hold(9'h000);
        wait_drain("bounce_release");
    endtask

    task automatic test_glitch;
        bus.SW_i[5] = 1'b1;
        tick(3);
        bus.SW_i[5] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            checks++;
            if (bus.GPIO_o[5] !== 1'b0 || bus.rise_o !== '0 || bus.changed_o !== 1'b0) begin
                failures++;
                $display("FAIL glitch gpio5=%b rise=%h changed=%b required 0/000/0",
                         bus.GPIO_o[5], bus.rise_o, bus.changed_o);
            end
        end
        wait_drain("glitch");
    endtask

    task automatic test_simultaneous;
        int cap;
        cap = edge_cnt + 1;
        drive_hold(9'h0A5);
        check_flip_edge("simul", cap, 9'h000, 9'h0A5);
        wait_drain("simul");
        drive_hold(9'h000);
        wait_drain("simul_fall");
    endtask

    task automatic test_back_to_back;
        drive_hold(9'h004);
        tick(SC + 1);
        drive_hold(9'h000);
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid;
        int cap;
        cap = edge_cnt + 1;
        bus.SW_i = 9'h002;
        wait_until(cap + 3);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.GPIO_o, bus.rise_o, bus.fall_o, bus.changed_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid_assert gpio=%h rise=%h fall=%h changed=%b required all 0",
                     bus.GPIO_o, bus.rise_o, bus.fall_o, bus.changed_o);
        end
        tick(2);
        checks++;
        if ({bus.GPIO_o, bus.rise_o, bus.fall_o, bus.changed_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid_hold gpio=%h rise=%h fall=%h changed=%b required all 0",
                     bus.GPIO_o, bus.rise_o, bus.fall_o, bus.changed_o);
        end
        rst = 1'b0;
        cap = edge_cnt + 1;
        expect_hold(9'h002);
        check_flip_edge("reset_mid", cap, 9'h000, 9'h002);
        wait_drain("reset_mid");
        drive_hold(9'h000);
        wait_drain("reset_mid_fall");
    endtask

    initial begin
        bus.SW_i = '0;
        test_reset();
        test_latency();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d required completion", edge_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
